// File: rtl/fmc_adc_ch_trig_detect.sv
// Per-channel internal threshold trigger: hysteresis arming, glitch filter and optional delay.
// Define FMC_ADC_TRIG_DLY_EN to build the DELAY state and its 32-bit delay counter.
module fmc_adc_ch_trig_detect #(
  parameter int g_glitch_width = 8
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_n_i,
  input  logic                      enable_i,
  input  logic                      polarity_i,
  input  logic signed [15:0]        thres_val_i,
  input  logic [15:0]               thres_hyst_i,
  input  logic [g_glitch_width-1:0] glitch_len_i,
  input  logic [31:0]               delay_i,
  input  logic signed [15:0]        data_i,
  input  logic                      valid_i,
  output logic                      trig_o,
  output logic                      armed_o,
  output logic                      busy_o
);

`ifdef FMC_ADC_TRIG_DLY_EN
  localparam int CNT_W = (g_glitch_width > 32) ? g_glitch_width : 32;
`else
  localparam int CNT_W = g_glitch_width;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISARMED,
    S_ARMED,
    S_FILTER,
`ifdef FMC_ADC_TRIG_DLY_EN
    S_DELAY,
`endif
    S_FIRE
  } state_t;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] x);
    if (x > 18'sd32767)
      sat16 = 16'sh7FFF;
    else if (x < -18'sd32768)
      sat16 = 16'sh8000;
    else
      sat16 = x[15:0];
  endfunction

  // Stage p0: input registers
  logic                      en_p0, pol_p0, vld_p0;
  logic signed [15:0]        data_p0, thres_p0;
  logic [15:0]               hyst_p0;
  logic [g_glitch_width-1:0] glitch_p0;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      en_p0  <= 1'b0;
      pol_p0 <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      en_p0  <= enable_i;
      pol_p0 <= polarity_i;
      vld_p0 <= valid_i;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    data_p0   <= data_i;
    thres_p0  <= thres_val_i;
    hyst_p0   <= thres_hyst_i;
    glitch_p0 <= glitch_len_i;
  end

  // Arm level and qualifying conditions on the registered sample
  logic signed [17:0] thr_ext, hyst_ext, arm_sum;
  logic signed [15:0] arm_lvl;
  logic               cross_hit, arm_hit;

  assign thr_ext   = {{2{thres_p0[15]}}, thres_p0};
  assign hyst_ext  = {2'b00, hyst_p0};
  assign arm_sum   = pol_p0 ? (thr_ext + hyst_ext) : (thr_ext - hyst_ext);
  assign arm_lvl   = sat16(arm_sum);
  assign cross_hit = pol_p0 ? (data_p0 < thres_p0) : (data_p0 > thres_p0);
  assign arm_hit   = pol_p0 ? (data_p0 > arm_lvl) : (data_p0 < arm_lvl);

  // Where a completed crossing goes: straight to FIRE, or into DELAY with delay_i latched
  state_t           go_state;
  logic [CNT_W-1:0] go_cnt;

`ifdef FMC_ADC_TRIG_DLY_EN
  logic [31:0] dly_p0;
  always_ff @(posedge sys_clk_i) dly_p0 <= delay_i;
  assign go_state = (dly_p0 == '0) ? S_FIRE : S_DELAY;
  assign go_cnt   = CNT_W'(dly_p0);
`else
  logic unused_dly;
  assign unused_dly = ^delay_i;
  assign go_state   = S_FIRE;
  assign go_cnt     = '0;
`endif

  // Stage p1: FSM state and shared filter/delay counter
  state_t           state_p1, state_nxt;
  logic [CNT_W-1:0] cnt_p1, cnt_nxt;
  logic             pol_p1;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_p1 <= S_IDLE;
      cnt_p1   <= '0;
      pol_p1   <= 1'b0;
    end else begin
      state_p1 <= state_nxt;
      cnt_p1   <= cnt_nxt;
      pol_p1   <= pol_p0;
    end
  end

  always_comb begin
    state_nxt = state_p1;
    cnt_nxt   = cnt_p1;
    if (!en_p0) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else if (state_p1 != S_IDLE && pol_p0 != pol_p1) begin
      state_nxt = S_DISARMED;
      cnt_nxt   = '0;
    end else begin
      case (state_p1)
        S_IDLE:     state_nxt = S_DISARMED;
        S_DISARMED: if (vld_p0 && arm_hit) state_nxt = S_ARMED;
        S_ARMED: begin
          if (vld_p0 && cross_hit) begin
            if (glitch_p0 == '0) begin
              state_nxt = go_state;
              cnt_nxt   = go_cnt;
            end else begin
              state_nxt = S_FILTER;
              cnt_nxt   = CNT_W'(glitch_p0);
            end
          end
        end
        S_FILTER: begin
          if (vld_p0) begin
            if (!cross_hit) begin
              state_nxt = arm_hit ? S_ARMED : S_DISARMED;
              cnt_nxt   = '0;
            end else if (cnt_p1 <= CNT_W'(1)) begin
              state_nxt = go_state;
              cnt_nxt   = go_cnt;
            end else begin
              cnt_nxt = cnt_p1 - CNT_W'(1);
            end
          end
        end
`ifdef FMC_ADC_TRIG_DLY_EN
        S_DELAY: begin
          if (vld_p0) begin
            if (cnt_p1 <= CNT_W'(1)) begin
              state_nxt = S_FIRE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_p1 - CNT_W'(1);
            end
          end
        end
`endif
        S_FIRE:     state_nxt = S_DISARMED;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  // Stage p2: registered status outputs
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      trig_o  <= 1'b0;
      armed_o <= 1'b0;
    end else begin
      trig_o  <= (state_p1 == S_FIRE);
      armed_o <= (state_p1 == S_ARMED) || (state_p1 == S_FILTER);
    end
  end

`ifdef FMC_ADC_TRIG_DLY_EN
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i)
      busy_o <= 1'b0;
    else
      busy_o <= (state_p1 == S_DELAY);
  end
`else
  assign busy_o = 1'b0;
`endif

endmodule
